// File: rtl/bcd_stopwatch_counter.sv
// Purpose : cascaded BCD mm..m:ss stopwatch counter with up/down, preset load, lap freeze, ovf/done flags.
// Latency : count/flags update on the edge that samples a tick, load or CLEAR; disp/enable are combinational from registers/state.
// Backpressure: none; every tick, load, lap and CLEAR is acted on in the cycle it is presented.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   state[2:0]           one-hot control state: IDLE=100, CLEAR=010, RUNNING=001
//   sec_pulse, dir       one-second tick strobe; 0=count up, 1=count down
//   load, load_val       preset strobe (IDLE only) and BCD preset {min MS-first, sec_tens, sec_ones}
//   lap                  toggles the display freeze
//   disp, lap_active     displayed BCD value, freeze indicator
//   enable, ovf, done    display enable (0 in CLEAR), sticky up-overflow, sticky down-reached-zero
module bcd_stopwatch_counter #(
  parameter int MIN_DIGITS = 2,
  parameter bit WRAP       = 1'b1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [2:0]                  state,
  input  logic                        sec_pulse,
  input  logic                        dir,
  input  logic                        load,
  input  logic [4*(MIN_DIGITS+2)-1:0] load_val,
  input  logic                        lap,
  output logic [4*(MIN_DIGITS+2)-1:0] disp,
  output logic                        lap_active,
  output logic                        enable,
  output logic                        ovf,
  output logic                        done
);

  localparam int N = MIN_DIGITS + 2;
  localparam int W = 4 * N;

  localparam logic [2:0] ST_IDLE    = 3'b100;
  localparam logic [2:0] ST_CLEAR   = 3'b010;
  localparam logic [2:0] ST_RUNNING = 3'b001;

  logic [W-1:0] r_count;
  logic [W-1:0] r_snap;
  logic         r_lap_active;
  logic         r_ovf;
  logic         r_done;

  logic [W-1:0] w_up;
  logic [W-1:0] w_dn;
  logic [W-1:0] w_load_san;
  logic [N-1:0] w_at_max;
  logic [N-1:0] w_at_zero;
  logic         w_is_max;
  logic         w_is_zero;
  logic         w_tick;
  logic         w_clear;
  logic         w_load;

  assign w_clear = (state == ST_CLEAR);
  assign w_load  = (state == ST_IDLE) && load;
  assign w_tick  = (state == ST_RUNNING) && sec_pulse;

  // Per-digit increment/decrement. A digit steps only when every lower
  // digit is at its rollover value (max for up, zero for down), so the
  // carry/borrow enable is an AND over the lower digits' flags.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_digit
      // Digit 1 is sec_tens (0-5); all others are decimal (0-9).
      localparam logic [3:0] LIM = (gi == 1) ? 4'd5 : 4'd9;
      logic [3:0] w_d;
      logic [3:0] w_ld;
      logic       w_cin;
      logic       w_bin;

      assign w_d  = r_count[4*gi +: 4];
      assign w_ld = load_val[4*gi +: 4];
      assign w_at_max[gi]  = (w_d == LIM);
      assign w_at_zero[gi] = (w_d == 4'd0);

      if (gi == 0) begin : g_lsb
        assign w_cin = 1'b1;
        assign w_bin = 1'b1;
      end else begin : g_upper
        assign w_cin = &w_at_max[gi-1:0];
        assign w_bin = &w_at_zero[gi-1:0];
      end

      assign w_up[4*gi +: 4] = !w_cin ? w_d : ((w_d == LIM) ? 4'd0 : w_d + 4'd1);
      assign w_dn[4*gi +: 4] = !w_bin ? w_d : ((w_d == 4'd0) ? LIM : w_d - 4'd1);
      // Out-of-range preset digits clamp to the digit's maximum.
      assign w_load_san[4*gi +: 4] = (w_ld > LIM) ? LIM : w_ld;
    end
  endgenerate

  assign w_is_max  = &w_at_max;
  assign w_is_zero = &w_at_zero;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count      <= '0;
      r_snap       <= '0;
      r_lap_active <= 1'b0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_clear) begin
      r_count      <= '0;
      r_snap       <= '0;
      r_lap_active <= 1'b0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // Snapshot takes the pre-update count, so a coincident tick or load
      // is not visible in the frozen display.
      if (lap) begin
        r_lap_active <= !r_lap_active;
        if (!r_lap_active) begin
          r_snap <= r_count;
        end
      end

      if (w_load) begin
        r_count <= w_load_san;
        r_ovf   <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_tick) begin
        if (!dir) begin
          if (w_is_max) begin
            r_ovf <= 1'b1;
            // w_up is all zeros at max, which is the wrap result.
            if (WRAP) begin
              r_count <= w_up;
            end
          end else begin
            r_count <= w_up;
          end
        end else begin
          // At zero the count holds: no borrow wrap to max.
          if (!w_is_zero) begin
            r_count <= w_dn;
          end
          if (w_is_zero || (w_dn == '0)) begin
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign disp       = r_lap_active ? r_snap : r_count;
  assign lap_active = r_lap_active;
  assign enable     = !w_clear;
  assign ovf        = r_ovf;
  assign done       = r_done;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
module tb_bcd_stopwatch_counter;

  localparam logic [2:0] ST_IDLE    = 3'b100;
  localparam logic [2:0] ST_CLEAR   = 3'b010;
  localparam logic [2:0] ST_RUNNING = 3'b001;

  logic        clk;
  logic        nrst;
  logic [2:0]  state;
  logic        sec_pulse;
  logic        dir;
  logic        load;
  logic [15:0] load_val;
  logic        lap;

  logic [15:0] disp_a, disp_b;
  logic        lap_a, lap_b, en_a, en_b, ovf_a, ovf_b, done_a, done_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [19:0] exp_a;
    logic [19:0] exp_b;
  } exp_t;

  exp_t sb_q[$];

  bcd_stopwatch_counter #(.MIN_DIGITS(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .nrst(nrst), .state(state), .sec_pulse(sec_pulse), .dir(dir),
    .load(load), .load_val(load_val), .lap(lap),
    .disp(disp_a), .lap_active(lap_a), .enable(en_a), .ovf(ovf_a), .done(done_a)
  );

  bcd_stopwatch_counter #(.MIN_DIGITS(2), .WRAP(1'b0)) u_sat (
    .clk(clk), .nrst(nrst), .state(state), .sec_pulse(sec_pulse), .dir(dir),
    .load(load), .load_val(load_val), .lap(lap),
    .disp(disp_b), .lap_active(lap_b), .enable(en_b), .ovf(ovf_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [15:0] d, input logic l,
                                     input logic e, input logic o, input logic dn);
    return {d, l, e, o, dn};
  endfunction

  task automatic expect_both(input string tag, input logic [19:0] ea, input logic [19:0] eb);
    exp_t e;
    e.tag   = tag;
    e.exp_a = ea;
    e.exp_b = eb;
    sb_q.push_back(e);
  endtask

  task automatic expect_same(input string tag, input logic [19:0] e);
    expect_both(tag, e, e);
  endtask

  // Pop every pending expectation and compare against both DUTs.
  task automatic compare();
    exp_t        e;
    logic [19:0] obs_a, obs_b;
    while (sb_q.size() > 0) begin
      e     = sb_q.pop_front();
      obs_a = {disp_a, lap_a, en_a, ovf_a, done_a};
      obs_b = {disp_b, lap_b, en_b, ovf_b, done_b};
      checks++;
      assert (obs_a === e.exp_a) else begin
        failures++;
        $error("FAIL %s wrap: observed disp/lap/en/ovf/done=%h expected %h", e.tag, obs_a, e.exp_a);
      end
      checks++;
      assert (obs_b === e.exp_b) else begin
        failures++;
        $error("FAIL %s sat: observed disp/lap/en/ovf/done=%h expected %h", e.tag, obs_b, e.exp_b);
      end
    end
  endtask

  // Each tick: pulse high for one cycle, low for one; returns at a negedge
  // after the edge that consumed the pulse.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sec_pulse = 1'b1;
      @(negedge clk);
      sec_pulse = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    state    = ST_IDLE;
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic lap_pulse();
    @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  initial begin
    nrst      = 1'b0;
    state     = ST_IDLE;
    sec_pulse = 1'b0;
    dir       = 1'b0;
    load      = 1'b0;
    load_val  = 16'h0000;
    lap       = 1'b0;

    #3;
    expect_same("reset", mk(16'h0000, 0, 1, 0, 0));
    compare();

    @(negedge clk);
    nrst  = 1'b1;
    state = ST_RUNNING;

    // Up counting and cascaded carries
    expect_same("up_60", mk(16'h0100, 0, 1, 0, 0));
    tick(60);
    compare();
    expect_same("up_599", mk(16'h0959, 0, 1, 0, 0));
    tick(539);
    compare();
    expect_same("up_600_min_tens_carry", mk(16'h1000, 0, 1, 0, 0));
    tick(1);
    compare();
    expect_same("up_3599", mk(16'h5959, 0, 1, 0, 0));
    tick(2999);
    compare();

    // Overflow: wrap vs saturate
    expect_same("load_9959", mk(16'h9959, 0, 1, 0, 0));
    do_load(16'h9959);
    compare();
    state = ST_RUNNING;
    expect_both("ovf_first", mk(16'h0000, 0, 1, 1, 0), mk(16'h9959, 0, 1, 1, 0));
    tick(1);
    compare();
    expect_both("ovf_sticky", mk(16'h0003, 0, 1, 1, 0), mk(16'h9959, 0, 1, 1, 0));
    tick(3);
    compare();

    // Down counting to zero
    dir = 1'b1;
    expect_same("load_0100_clears_ovf", mk(16'h0100, 0, 1, 0, 0));
    do_load(16'h0100);
    compare();
    state = ST_RUNNING;
    expect_same("down_borrow", mk(16'h0059, 0, 1, 0, 0));
    tick(1);
    compare();
    expect_same("down_zero_done", mk(16'h0000, 0, 1, 0, 1));
    tick(59);
    compare();
    expect_same("down_hold_zero", mk(16'h0000, 0, 1, 0, 1));
    tick(1);
    compare();

    // dir sampled per tick
    dir = 1'b0;
    do_load(16'h0100);
    state = ST_RUNNING;
    expect_same("dir_up", mk(16'h0101, 0, 1, 0, 0));
    tick(1);
    compare();
    dir = 1'b1;
    expect_same("dir_down", mk(16'h0100, 0, 1, 0, 0));
    tick(1);
    compare();
    dir = 1'b0;

    // Lap freeze
    do_load(16'h0010);
    state = ST_RUNNING;
    expect_same("lap_on", mk(16'h0010, 1, 1, 0, 0));
    lap_pulse();
    compare();
    expect_same("lap_frozen", mk(16'h0010, 1, 1, 0, 0));
    tick(5);
    compare();
    expect_same("lap_off", mk(16'h0015, 0, 1, 0, 0));
    lap_pulse();
    compare();
    @(negedge clk);
    lap       = 1'b1;
    sec_pulse = 1'b1;
    expect_same("lap_with_tick_pretick", mk(16'h0015, 1, 1, 0, 0));
    @(negedge clk);
    lap       = 1'b0;
    sec_pulse = 1'b0;
    compare();
    expect_same("lap_with_tick_release", mk(16'h0016, 0, 1, 0, 0));
    lap_pulse();
    compare();

    // Load + lap in the same IDLE cycle: snapshot holds pre-load count
    @(negedge clk);
    state    = ST_IDLE;
    load     = 1'b1;
    load_val = 16'h0300;
    lap      = 1'b1;
    expect_same("load_lap_snapshot", mk(16'h0016, 1, 1, 0, 0));
    @(negedge clk);
    load = 1'b0;
    lap  = 1'b0;
    compare();
    expect_same("load_lap_count", mk(16'h0300, 0, 1, 0, 0));
    lap_pulse();
    compare();

    // Sanitised load, ignored loads
    expect_same("load_sanitise", mk(16'h0959, 0, 1, 0, 0));
    do_load(16'h0A7F);
    compare();
    @(negedge clk);
    state    = ST_RUNNING;
    load     = 1'b1;
    load_val = 16'h1234;
    expect_same("load_in_running", mk(16'h0959, 0, 1, 0, 0));
    @(negedge clk);
    load = 1'b0;
    compare();
    @(negedge clk);
    state     = 3'b000;
    load      = 1'b1;
    sec_pulse = 1'b1;
    expect_same("illegal_state", mk(16'h0959, 0, 1, 0, 0));
    @(negedge clk);
    load      = 1'b0;
    sec_pulse = 1'b0;
    compare();
    @(negedge clk);
    state = ST_CLEAR;
    load  = 1'b1;
    expect_same("load_clear", mk(16'h0000, 0, 0, 0, 0));
    @(negedge clk);
    load = 1'b0;
    compare();

    // Mid-run CLEAR with flags and lap set
    do_load(16'h9959);
    state = ST_RUNNING;
    tick(1);
    expect_both("pre_clear", mk(16'h0000, 1, 1, 1, 0), mk(16'h9959, 1, 1, 1, 0));
    lap_pulse();
    compare();
    @(negedge clk);
    state = ST_CLEAR;
    lap   = 1'b1;
    #1;
    expect_both("clear_enable_comb", mk(16'h0000, 1, 0, 1, 0), mk(16'h9959, 1, 0, 1, 0));
    compare();
    @(negedge clk);
    lap = 1'b0;
    expect_same("clear_result", mk(16'h0000, 0, 0, 0, 0));
    compare();

    // Asynchronous reset mid-cycle
    do_load(16'h0123);
    state = ST_RUNNING;
    dir   = 1'b1;
    tick(4);
    lap_pulse();
    expect_same("pre_async", mk(16'h0119, 1, 1, 0, 0));
    compare();
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    expect_same("async_reset", mk(16'h0000, 0, 1, 0, 0));
    compare();
    @(negedge clk);
    nrst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
